// File: rtl/uart_pkg.sv
// Shared UART constants: baud-select encoding, table divisor math and the
// oversampling lower bound on the bit divisor.
package uart_pkg;

    typedef enum logic [2:0] {
        BAUD_9600   = 3'd0,
        BAUD_19200  = 3'd1,
        BAUD_38400  = 3'd2,
        BAUD_57600  = 3'd3,
        BAUD_115200 = 3'd4,
        BAUD_230400 = 3'd5,
        BAUD_460800 = 3'd6,
        BAUD_CUSTOM = 3'd7
    } baud_sel_e;

    localparam int OVS_DEFAULT = 16;
    // Each oversample interval needs at least two cycles.
    localparam int OVS_MIN_N   = 2 * OVS_DEFAULT - 1;

    // Terminal count N = round(clk_hz / baud) - 1.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud - 1;
    endfunction

    function automatic int min_div(input int ovs);
        return 2 * ovs - 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// Control/tick bundle between the UART datapath and the baud generator.
interface uart_baud_gen_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic [2:0]       baud_sel;
    logic [CNT_W-1:0] div_custom;
    logic             bit_tick;
    logic             mid_tick;
    logic             ovs_tick;
    logic             div_clamped;

    modport master (
        output en, baud_sel, div_custom,
        input  bit_tick, mid_tick, ovs_tick, div_clamped
    );

    modport slave (
        input  en, baud_sel, div_custom,
        output bit_tick, mid_tick, ovs_tick, div_clamped
    );
endinterface

// File: rtl/uart_baud_lut.sv
// Maps a baud selection to its clamped bit count N, half count H and
// oversample count M. OVS must be a power of two in 2..64.
module uart_baud_lut
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int CNT_W  = 16,
    parameter int OVS    = 16
) (
    input  logic [2:0]       baud_sel_i,
    input  logic [CNT_W-1:0] div_custom_i,
    output logic [CNT_W-1:0] n_o,
    output logic [CNT_W-1:0] h_o,
    output logic [CNT_W-1:0] m_o,
    output logic             clamped_o
);
    localparam int OVS_LOG2 = $clog2(OVS);
    localparam logic [CNT_W-1:0] MIN_N = CNT_W'(min_div(OVS));

    localparam logic [CNT_W-1:0] N_9600   = CNT_W'(baud_div(CLK_HZ, 9600));
    localparam logic [CNT_W-1:0] N_19200  = CNT_W'(baud_div(CLK_HZ, 19200));
    localparam logic [CNT_W-1:0] N_38400  = CNT_W'(baud_div(CLK_HZ, 38400));
    localparam logic [CNT_W-1:0] N_57600  = CNT_W'(baud_div(CLK_HZ, 57600));
    localparam logic [CNT_W-1:0] N_115200 = CNT_W'(baud_div(CLK_HZ, 115200));
    localparam logic [CNT_W-1:0] N_230400 = CNT_W'(baud_div(CLK_HZ, 230400));
    localparam logic [CNT_W-1:0] N_460800 = CNT_W'(baud_div(CLK_HZ, 460800));

    logic [CNT_W-1:0] raw_n;
    logic [CNT_W:0]   n_plus1;
    logic [CNT_W:0]   m_wide;

    always_comb begin
        // NOTE: every output of a combinational block is given a value before
        // any branch, so no path can leave it holding state (no latch).
        raw_n   = div_custom_i;
        case (baud_sel_e'(baud_sel_i))
            BAUD_9600:   raw_n = N_9600;
            BAUD_19200:  raw_n = N_19200;
            BAUD_38400:  raw_n = N_38400;
            BAUD_57600:  raw_n = N_57600;
            BAUD_115200: raw_n = N_115200;
            BAUD_230400: raw_n = N_230400;
            BAUD_460800: raw_n = N_460800;
            default:     raw_n = div_custom_i;
        endcase

        clamped_o = (raw_n < MIN_N);
        n_o       = clamped_o ? MIN_N : raw_n;
        h_o       = n_o >> 1;
        // N+1 is formed one bit wider so a full-scale divisor does not wrap.
        n_plus1   = {1'b0, n_o} + {{CNT_W{1'b0}}, 1'b1};
        m_wide    = (n_plus1 >> OVS_LOG2) - {{CNT_W{1'b0}}, 1'b1};
        m_o       = m_wide[CNT_W-1:0];
    end

endmodule

// File: rtl/uart_baud_gen.sv
// Baud tick generator: divisor latch, bit/oversample counters and the
// registered bit, mid-bit and oversample ticks.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int CNT_W  = 16,
    parameter int OVS    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_baud_gen_if.slave bus
);
    localparam int OVS_W = $clog2(OVS) + 1;

    // Reset divisor is the 9600-baud table entry, clamped like the LUT does.
    localparam int  RST_RAW   = baud_div(CLK_HZ, 9600);
    localparam bit  RST_CLAMP = (RST_RAW < min_div(OVS));
    localparam int  RST_N_INT = RST_CLAMP ? min_div(OVS) : RST_RAW;
    localparam logic [CNT_W-1:0] RST_N = CNT_W'(RST_N_INT);
    localparam logic [CNT_W-1:0] RST_H = CNT_W'(RST_N_INT / 2);
    localparam logic [CNT_W-1:0] RST_M = CNT_W'(((RST_N_INT + 1) >> $clog2(OVS)) - 1);

    logic [CNT_W-1:0] lut_n, lut_h, lut_m;
    logic             lut_clamped;

    uart_baud_lut #(
        .CLK_HZ (CLK_HZ),
        .CNT_W  (CNT_W),
        .OVS    (OVS)
    ) u_lut (
        .baud_sel_i   (bus.baud_sel),
        .div_custom_i (bus.div_custom),
        .n_o          (lut_n),
        .h_o          (lut_h),
        .m_o          (lut_m),
        .clamped_o    (lut_clamped)
    );

    logic [CNT_W-1:0] n_q, n_d, h_q, h_d, m_q, m_d;
    logic             clamped_q, clamped_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, oc_q, oc_d;
    logic [OVS_W-1:0] ovs_n_q, ovs_n_d;
    logic             bit_q, bit_d, mid_q, mid_d, ovs_q, ovs_d;
    logic             wrap, oc_hit, ovs_ok;

    always_comb begin
        n_d       = n_q;
        h_d       = h_q;
        m_d       = m_q;
        clamped_d = clamped_q;
        if (!bus.en) begin
            n_d       = lut_n;
            h_d       = lut_h;
            m_d       = lut_m;
            clamped_d = lut_clamped;
        end

        wrap   = bus.en && (cnt_q == n_q);
        oc_hit = (oc_q == m_q);
        // Caps the bit at OVS ticks; the remainder cycles stretch the last gap.
        ovs_ok = (ovs_n_q < OVS_W'(OVS));

        cnt_d   = '0;
        oc_d    = '0;
        ovs_n_d = '0;
        if (bus.en && !wrap) begin
            cnt_d   = cnt_q + 1'b1;
            oc_d    = oc_hit ? '0 : oc_q + 1'b1;
            ovs_n_d = ovs_n_q + OVS_W'(oc_hit && ovs_ok);
        end

        bit_d = wrap;
        mid_d = bus.en && (cnt_q == h_q);
        ovs_d = bus.en && oc_hit && ovs_ok;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q       <= RST_N;
            h_q       <= RST_H;
            m_q       <= RST_M;
            clamped_q <= RST_CLAMP;
            cnt_q     <= '0;
            oc_q      <= '0;
            ovs_n_q   <= '0;
            bit_q     <= 1'b0;
            mid_q     <= 1'b0;
            ovs_q     <= 1'b0;
        end else begin
            n_q       <= n_d;
            h_q       <= h_d;
            m_q       <= m_d;
            clamped_q <= clamped_d;
            cnt_q     <= cnt_d;
            oc_q      <= oc_d;
            ovs_n_q   <= ovs_n_d;
            bit_q     <= bit_d;
            mid_q     <= mid_d;
            ovs_q     <= ovs_d;
        end
    end

    assign bus.bit_tick    = bit_q;
    assign bus.mid_tick    = mid_q;
    assign bus.ovs_tick    = ovs_q;
    assign bus.div_clamped = clamped_q;

endmodule
